// File: rtl/jtlabrun_dwnld_queue.sv
// jtlabrun_dwnld_queue
// Front end for the ioctl ROM download stream. It decodes each byte into an
// SDRAM byte write or a PROM load pulse. A small ordered queue holds the bytes
// that arrive while the SDRAM controller is busy, so bytes are neither lost
// nor reordered (unless the queue overflows, which sets a sticky flag).
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   downloading  ROM download in progress
//   ioctl_addr   download byte address (25 bits)
//   ioctl_data   download byte
//   ioctl_wr     one-cycle byte strobe, only honoured while downloading
//   sdram_ack    SDRAM controller accepted the current write
//   prog_addr    SDRAM word address, or byte offset into the PROM region
//   prog_data    byte being written
//   prog_mask    active-low byte enables (2'b11 for PROM bytes)
//   prog_we      SDRAM write request, held until sdram_ack
//   prom_we      one-cycle PROM write pulse
//   dwnld_busy   download active, bytes queued, or a write in flight
//   ovf          sticky queue overflow flag, cleared only by rst
//
// Handshake: prog_we rises when an SDRAM entry leaves the queue and stays high,
// with prog_addr/prog_data/prog_mask stable, up to and including the cycle in
// which sdram_ack is sampled high. It is low after that edge, and the next
// entry is taken one cycle later. sdram_ack is ignored while no request is up.
module jtlabrun_dwnld_queue #(
   parameter logic [21:0] PROM_START = 22'h6_0000,
   parameter int          QW         = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        downloading,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   input  logic        sdram_ack,
   output logic [21:0] prog_addr,
   output logic [7:0]  prog_data,
   output logic [1:0]  prog_mask,
   output logic        prog_we,
   output logic        prom_we,
   output logic        dwnld_busy,
   output logic        ovf
);

   localparam int          DEPTH   = 1 << QW;
   localparam logic [QW:0] DEPTH_C = DEPTH[QW:0];

   // Entries are stored already decoded so the output side is a plain copy.
   typedef struct packed {
      logic        prom;
      logic [21:0] addr;
      logic [1:0]  mask;
      logic [7:0]  data;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SDW   = 2'd1,
      PROMW = 2'd2
   } state_t;

   state_t         state;
   entry_t         mem [DEPTH];
   entry_t         in_entry;
   logic [QW-1:0]  rd_ptr;
   logic [QW-1:0]  wr_ptr;
   logic [QW:0]    count;
   logic           push_req;
   logic           push_ok;
   logic           pop;
   logic           full;

   // Region decode on the full 25-bit address. The PROM offset only needs the
   // low 22 bits of the difference, so the subtraction is done at that width.
   always_comb begin
      in_entry      = '0;
      in_entry.data = ioctl_data;
      if (ioctl_addr < {3'b000, PROM_START}) begin
         in_entry.prom = 1'b0;
         in_entry.addr = ioctl_addr[22:1];
         in_entry.mask = ioctl_addr[0] ? 2'b01 : 2'b10;
      end else begin
         in_entry.prom = 1'b1;
         in_entry.addr = ioctl_addr[21:0] - PROM_START;
         in_entry.mask = 2'b11;
      end
   end

   assign full     = (count == DEPTH_C);
   assign pop      = (state == IDLE) && (count != '0);
   assign push_req = ioctl_wr && downloading;
   // A full queue still accepts a byte when the head leaves on the same edge.
   assign push_ok  = push_req && (!full || pop);

   assign dwnld_busy = downloading || (count != '0) || (state != IDLE);

   // Storage carries no reset: count and pointers define which slots are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= in_entry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && full && !pop) ovf <= 1'b1;
      end
   end

   // Output FSM. Outputs are registered and hold their last values in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         prog_addr <= '0;
         prog_data <= '0;
         prog_mask <= 2'b11;
         prog_we   <= 1'b0;
         prom_we   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  prog_addr <= mem[rd_ptr].addr;
                  prog_data <= mem[rd_ptr].data;
                  prog_mask <= mem[rd_ptr].mask;
                  if (mem[rd_ptr].prom) begin
                     prom_we <= 1'b1;
                     state   <= PROMW;
                  end else begin
                     prog_we <= 1'b1;
                     state   <= SDW;
                  end
               end
            end
            SDW: begin
               if (sdram_ack) begin
                  prog_we <= 1'b0;
                  state   <= IDLE;
               end
            end
            PROMW: begin
               prom_we <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               prog_we <= 1'b0;
               prom_we <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtlabrun_dwnld_queue.sv
// Bench for jtlabrun_dwnld_queue: decode table, hand sequences for the
// multi-cycle corner cases, and randomized traffic against a queue-based model.
module tb_jtlabrun_dwnld_queue;

   localparam logic [24:0] PROM_START = 25'h06_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        downloading;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wr;
   logic        sdram_ack;
   logic [21:0] prog_addr;
   logic [7:0]  prog_data;
   logic [1:0]  prog_mask;
   logic        prog_we;
   logic        prom_we;
   logic        dwnld_busy;
   logic        ovf;

   int total = 0;
   int bad   = 0;

   jtlabrun_dwnld_queue dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .ioctl_addr  (ioctl_addr),
      .ioctl_data  (ioctl_data),
      .ioctl_wr    (ioctl_wr),
      .sdram_ack   (sdram_ack),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_mask   (prog_mask),
      .prog_we     (prog_we),
      .prom_we     (prom_we),
      .dwnld_busy  (dwnld_busy),
      .ovf         (ovf)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic        prom;
      logic [21:0] addr;
      logic [1:0]  mask;
      logic [7:0]  data;
   } ent_t;

   ent_t        m_q[$];
   logic        m_sd;
   logic        m_pr;
   logic [21:0] m_addr;
   logic [7:0]  m_data;
   logic [1:0]  m_mask;
   logic        m_ovf;

   function automatic ent_t decode(input logic [24:0] a, input logic [7:0] d);
      ent_t e;
      e.data = d;
      if (a < PROM_START) begin
         e.prom = 1'b0;
         e.addr = 22'((a / 2) % (1 << 22));
         e.mask = (a % 2 == 1) ? 2'b01 : 2'b10;
      end else begin
         e.prom = 1'b1;
         e.addr = 22'((a - PROM_START) % (1 << 22));
         e.mask = 2'b11;
      end
      return e;
   endfunction

   task automatic model_step();
      logic was_idle;
      ent_t e;
      if (rst) begin
         m_q.delete();
         m_sd = 0; m_pr = 0; m_addr = 0; m_data = 0; m_mask = 2'b11; m_ovf = 0;
      end else begin
         was_idle = !m_sd && !m_pr;
         if (m_pr) m_pr = 0;
         if (m_sd && sdram_ack) m_sd = 0;
         if (was_idle && m_q.size() > 0) begin
            e = m_q.pop_front();
            m_addr = e.addr; m_data = e.data; m_mask = e.mask;
            if (e.prom) m_pr = 1; else m_sd = 1;
         end
         if (ioctl_wr && downloading) begin
            if (m_q.size() < 4) m_q.push_back(decode(ioctl_addr, ioctl_data));
            else m_ovf = 1;
         end
      end
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("prog_we",    32'(prog_we),    32'(m_sd));
      chk("prom_we",    32'(prom_we),    32'(m_pr));
      chk("ovf",        32'(ovf),        32'(m_ovf));
      chk("dwnld_busy", 32'(dwnld_busy), 32'(downloading || m_q.size() > 0 || m_sd || m_pr));
      chk("prog_addr",  32'(prog_addr),  32'(m_addr));
      chk("prog_data",  32'(prog_data),  32'(m_data));
      chk("prog_mask",  32'(prog_mask),  32'(m_mask));
   endtask

   // Inputs change only after the sample point, so they are stable at the edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1; ioctl_wr = 0; sdram_ack = 0;
      tick();
      rst = 0;
   endtask

   task automatic strobe(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a; ioctl_data = d; ioctl_wr = 1;
      tick();
      ioctl_wr = 0;
   endtask

   // ---------------- decode table ----------------
   typedef struct {
      logic [24:0] addr;
      logic [7:0]  data;
      logic [21:0] exp_addr;
      logic [1:0]  exp_mask;
      logic        exp_prom;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int cnt;
      int fall_idx;
      int prom_idx;
      int writes;
      logic prev_we;
      logic [21:0] seen[$];

      vecs[0] = '{25'h0000005,   8'hA5, 22'h000002, 2'b01, 1'b0};
      vecs[1] = '{25'h0060013,   8'h0C, 22'h000013, 2'b11, 1'b1};
      vecs[2] = '{25'h005FFFF,   8'h11, 22'h02FFFF, 2'b01, 1'b0};
      vecs[3] = '{25'h0060000,   8'h22, 22'h000000, 2'b11, 1'b1};
      vecs[4] = '{25'h0000000,   8'h33, 22'h000000, 2'b10, 1'b0};
      vecs[5] = '{25'h1FFFFFF,   8'h44, 22'h39FFFF, 2'b11, 1'b1};
      vecs[6] = '{25'h0800001,   8'h55, 22'h3A0001, 2'b11, 1'b1};
      vecs[7] = '{25'h003FFFE,   8'h66, 22'h01FFFF, 2'b10, 1'b0};

      rst = 1; downloading = 1; ioctl_addr = 0; ioctl_data = 0; ioctl_wr = 0; sdram_ack = 0;
      tick();
      tick();
      // Reset state with downloading high
      chk("rst_mask", 32'(prog_mask), 32'h3);
      chk("rst_we",   32'(prog_we),   32'h0);
      chk("rst_busy", 32'(dwnld_busy), 32'h1);
      rst = 0;

      foreach (vecs[i]) begin
         do_reset();
         strobe(vecs[i].addr, vecs[i].data);
         tick();
         chk("vec_addr", 32'(prog_addr), 32'(vecs[i].exp_addr));
         chk("vec_mask", 32'(prog_mask), 32'(vecs[i].exp_mask));
         chk("vec_data", 32'(prog_data), 32'(vecs[i].data));
         chk("vec_we",   32'(prog_we),   32'(!vecs[i].exp_prom));
         chk("vec_prom", 32'(prom_we),   32'(vecs[i].exp_prom));
         sdram_ack = 1; tick(); sdram_ack = 0;
         chk("vec_done", 32'(prog_we | prom_we), 32'h0);
         tick();
      end

      // SDRAM byte: request held four cycles, then busy drops with downloading
      do_reset();
      downloading = 1;
      strobe(25'h0000005, 8'hA5);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         sdram_ack = (i == 4);
         tick();
         if (i == 0) begin
            chk("sd_addr", 32'(prog_addr), 32'h2);
            chk("sd_mask", 32'(prog_mask), 32'h1);
            chk("sd_data", 32'(prog_data), 32'hA5);
         end
         if (prog_we) cnt++;
      end
      sdram_ack = 0;
      chk("sd_we_cycles", 32'(cnt), 32'd4);
      downloading = 0;
      tick();
      chk("sd_busy_end", 32'(dwnld_busy), 32'h0);

      // PROM byte: single pulse, no SDRAM request
      do_reset();
      downloading = 1;
      strobe(25'h0060013, 8'h0C);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (prom_we) cnt++;
         chk("pr_no_sdw", 32'(prog_we), 32'h0);
      end
      chk("pr_pulses", 32'(cnt), 32'd1);
      chk("pr_addr", 32'(prog_addr), 32'h13);

      // Ordering: PROM byte waits for the pending SDRAM byte
      do_reset();
      strobe(25'h0000000, 8'h01);
      strobe(25'h0060000, 8'h02);
      fall_idx = -1; prom_idx = -1; prev_we = prog_we;
      for (int i = 0; i < 20; i++) begin
         sdram_ack = (i == 10);
         tick();
         if (prev_we && !prog_we && fall_idx < 0) fall_idx = i;
         if (prom_we && prom_idx < 0) prom_idx = i;
         prev_we = prog_we;
      end
      sdram_ack = 0;
      chk("ord_fall_seen", 32'(fall_idx >= 0), 32'h1);
      chk("ord_prom_after", 32'(prom_idx), 32'(fall_idx + 1));

      // Burst and overflow: six strobes, one in flight, four queued, one dropped
      do_reset();
      for (int i = 0; i < 6; i++) strobe(25'(32'h100 + 2 * i), 8'(i));
      chk("ovf_set", 32'(ovf), 32'h1);
      seen.delete(); prev_we = prog_we;
      if (prog_we) seen.push_back(prog_addr);
      sdram_ack = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (prog_we && !prev_we) seen.push_back(prog_addr);
         prev_we = prog_we;
      end
      sdram_ack = 0;
      chk("burst_count", 32'(seen.size()), 32'd5);
      for (int i = 0; i < 5 && i < seen.size(); i++)
         chk("burst_addr", 32'(seen[i]), 32'(32'h80 + i));

      // Reset mid-request: ovf is still set from the burst above
      strobe(25'h0000010, 8'hAA);
      strobe(25'h0000012, 8'hBB);
      strobe(25'h0000014, 8'hCC);
      chk("mid_we_before", 32'(prog_we), 32'h1);
      rst = 1; tick(); rst = 0;
      chk("mid_we_after", 32'(prog_we), 32'h0);
      chk("mid_ovf_after", 32'(ovf), 32'h0);
      downloading = 0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         sdram_ack = 1;
         tick();
         if (prog_we || prom_we) cnt++;
      end
      sdram_ack = 0;
      chk("mid_no_writes", 32'(cnt), 32'd0);

      // Drain after download end, ack every fourth cycle
      downloading = 1;
      strobe(25'h0000020, 8'h01);
      strobe(25'h0000021, 8'h02);
      strobe(25'h0000022, 8'h03);
      downloading = 0;
      writes = 0; prev_we = prog_we;
      if (prog_we) writes = 1;
      for (int i = 0; i < 40; i++) begin
         sdram_ack = (i % 4 == 3);
         tick();
         if (prog_we && !prev_we) writes++;
         prev_we = prog_we;
         chk("drain_busy", 32'(dwnld_busy), 32'(!(writes == 3 && !prog_we)));
      end
      sdram_ack = 0;
      chk("drain_writes", 32'(writes), 32'd3);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         downloading = ($urandom_range(0, 9) != 0);
         ioctl_wr = ($urandom_range(0, 1) == 1);
         sdram_ack = ($urandom_range(0, 2) == 0);
         ioctl_data = 8'($urandom);
         case ($urandom_range(0, 4))
            0: ioctl_addr = 25'($urandom_range(0, 32'h5FFFF));
            1: ioctl_addr = 25'($urandom_range(32'h60000, 32'h1FFFFFF));
            2: ioctl_addr = 25'h005FFFF;
            3: ioctl_addr = 25'h0060000;
            default: ioctl_addr = 25'($urandom);
         endcase
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jtlabrun_dwnld_queue.md
# jtlabrun_dwnld_queue

Download-stream front end for the Labyrinth Runner core. Accepts the byte-wide ioctl ROM stream and turns it into SDRAM byte-write requests or PROM load pulses. It feeds the game's `prog_*` and `prom_we` nets and the SDRAM write port. A 4-entry ordered queue absorbs ioctl bursts while the SDRAM controller is busy, so no byte is lost and bytes are never reordered.

## Interface

Parameters:
- PROM_START, 22'h6_0000, byte address where the PROM region of the download begins.
- QW, 2, log2 of queue depth (depth 4).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- downloading  in  1  high while the ROM download is in progress.
- ioctl_addr  in  25  download byte address.
- ioctl_data  in  8  download byte.
- ioctl_wr  in  1  one-cycle byte strobe.
- sdram_ack  in  1  SDRAM controller accepted the current write.
- prog_addr  out  22  word address for the SDRAM region; byte offset from PROM_START for the PROM region.
- prog_data  out  8  byte being written.
- prog_mask  out  2  active-low byte enable.
- prog_we  out  1  SDRAM write request, level, held until acknowledged.
- prom_we  out  1  one-cycle PROM write pulse.
- dwnld_busy  out  1  download or drain in progress.
- ovf  out  1  sticky overflow flag.

## Operation

- Enqueue: on an edge where ioctl_wr=1 and downloading=1, push {region, addr, data} into the queue. ioctl_wr is ignored when downloading=0.
- Region decode:
  - addr < PROM_START: SDRAM region.
  - addr ≥ PROM_START: PROM region. The comparison is on the full 25-bit address.
- SDRAM entry:
  - prog_addr = addr[22:1].
  - prog_data = data.
  - prog_mask = 2'b10 if addr[0]=0 (low byte), 2'b01 if addr[0]=1.
- PROM entry:
  - prog_addr = (addr − PROM_START)[21:0].
  - prog_data = data.
  - prog_mask = 2'b11.
- Output FSM has three states:
  - IDLE: if the queue is non-empty, pop the head onto the prog_* outputs. Go to SDW if it is an SDRAM entry (prog_we←1), or to PROMW if it is a PROM entry (prom_we←1).
  - SDW: hold prog_addr, prog_data, prog_mask and prog_we stable. On an edge with sdram_ack=1, set prog_we←0 and go to IDLE.
  - PROMW: set prom_we←0 and go to IDLE. prom_we is therefore high for exactly one cycle.
- Ordering: strict FIFO across both regions. A PROM byte never overtakes a pending SDRAM byte.
- Full queue:
  - A push while 4 entries are held and no pop occurs on the same edge is dropped, and ovf←1.
  - A push and a pop on the same edge when full are both accepted; count is unchanged.
  - ovf clears only on rst.
- Empty queue: the FSM stays in IDLE and the outputs hold their last values, with prog_we=0 and prom_we=0.
- Download end: when downloading falls, queued entries still drain normally.
- dwnld_busy = downloading | (queue count≠0) | (state≠IDLE).
- sdram_ack outside SDW is ignored.

## Timing

- Reset values:
  - prog_addr=0, prog_data=0, prog_mask=2'b11.
  - prog_we=0, prom_we=0, ovf=0.
  - Queue empty, state IDLE.
  - dwnld_busy = downloading, applied combinationally.
- rst mid-operation flushes the queue and drops prog_we on the next edge, even without an ack.
- Latency, empty queue and IDLE:
  - ioctl_wr sampled at edge k → entry pushed at k.
  - Popped at k+1 → prog_we or prom_we high from edge k+1.
- SDRAM handshake: prog_we is high from edge k+1 up to and including the cycle in which sdram_ack=1 is sampled at edge m. It is low after edge m.
- Back-to-back entries: the next entry is popped at edge m+1, which gives a minimum of one low cycle between requests.
- PROM throughput: one entry per 2 cycles.

## Test plan

- SDRAM byte: reset, then ioctl_addr=0x00005, data=0xA5, single strobe; ack 3 cycles later → prog_addr=0x00002, prog_mask=2'b01, prog_data=0xA5. prog_we is high for exactly 4 cycles, then low; dwnld_busy falls after downloading drops.
- PROM byte: ioctl_addr=0x60013, data=0x0C → prog_addr=0x00013, prog_mask=2'b11, prom_we high for exactly 1 cycle, prog_we stays 0.
- Ordering: SDRAM write to 0x00000, then PROM write to 0x60000 one cycle later, ack held off 10 cycles → prom_we is not asserted until 1 cycle after prog_we falls.
- Burst and overflow: 6 consecutive strobes with ack held low → the first is in flight and 4 are queued. The sixth is dropped and ovf=1. After 5 acks, exactly 5 writes with the correct addresses appear, in order.
- Drain after end: 3 strobes, downloading drops the next cycle, ack every 4 cycles → all 3 writes are issued and dwnld_busy stays high until the last prog_we falls.
- Reset mid-request: rst pulsed while prog_we=1 with 2 entries queued → on the next edge prog_we=0, ovf=0; no further writes occur after rst releases.
